byte_en_mem: RTL and testbench

- Single-port-write, single-port-read 32-bit data memory with per-byte write enables, used as the core's data RAM for load/store (SW/SH/SB) traffic.
- Writes are synchronous; reads are asynchronous (combinational) from a separate read address.
- Byte-addressed interface, word-organised storage; the caller places store data on the correct byte lanes.

---
 rtl/byte_en_mem.sv | 47 ++++
 tb/tb_byte_en_mem.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/byte_en_mem.sv
// Word-organised data RAM with per-byte write enables, synchronous write and
// combinational read. Byte addresses are reduced to a word index; excess bits alias.
module byte_en_mem #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adrs_rd,
  input  logic [31:0] adrs_wr,
  input  logic        wr_en,
  input  logic [3:0]  byt_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH] = '{default: 32'h0};
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_mask;

  assign rd_idx = adrs_rd[AW+1:2];
  assign wr_idx = adrs_wr[AW+1:2];

  always_comb begin
    wr_mask = {{8{byt_en[3]}}, {8{byt_en[2]}}, {8{byt_en[1]}}, {8{byt_en[0]}}};
  end

  // Reset wins over a coincident write; the write is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: 32'h0};
    end else if (wr_en) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // Read straight from the array: a same-cycle write shows up after the edge.
  assign rd_data = mem[rd_idx];

  // Lane offset and out-of-range bits are intentionally discarded.
  logic unused_adrs_bits;
  assign unused_adrs_bits = ^{adrs_rd[31:AW+2], adrs_rd[1:0],
                              adrs_wr[31:AW+2], adrs_wr[1:0]};

endmodule

// File: tb/tb_byte_en_mem.sv
// Scoreboard bench for byte_en_mem: expected read values are queued as each
// stimulus is applied and compared once the combinational read settles.
module tb_byte_en_mem;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adrs_rd = '0;
  logic [31:0] adrs_wr = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  byt_en = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  byte_en_mem #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .adrs_rd (adrs_rd),
    .adrs_wr (adrs_wr),
    .wr_en   (wr_en),
    .byt_en  (byt_en),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Queue the expectation, let the read settle, then retire it.
  task automatic sample(input string tag, input logic [31:0] exp);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq(t, rd_data, e);
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    adrs_rd = addr;
    sample(tag, exp);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                          input logic en);
    @(negedge clk);
    adrs_wr = addr;
    wr_data = data;
    byt_en  = be;
    wr_en   = en;
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    byt_en = '0;
  endtask

  initial begin
    expect_rd("init_zero", 32'h0000_0040, 32'h0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_rd("rst_0x00", 32'h00, 32'h0);

    do_write(32'h00, 32'hAABB_CCDD, 4'b1111, 1'b1);
    expect_rd("word_wr", 32'h00, 32'hAABB_CCDD);

    do_write(32'h04, 32'h0000_EEFF, 4'b0011, 1'b1);
    expect_rd("half_wr", 32'h04, 32'h0000_EEFF);
    do_write(32'h08, 32'h0000_0055, 4'b0001, 1'b1);
    expect_rd("byte_wr", 32'h08, 32'h0000_0055);

    do_write(32'h0C, 32'h1122_3344, 4'b1010, 1'b1);
    expect_rd("sparse_wr", 32'h0C, 32'h1100_3300);
    do_write(32'h0C, 32'hFFFF_FFFF, 4'b0100, 1'b1);
    expect_rd("lane_keep", 32'h0C, 32'h11FF_3300);

    expect_rd("unwritten", 32'h10, 32'h0);

    do_write(32'h00 + 4 * DEPTH, 32'hCAFE_BABE, 4'b1111, 1'b1);
    expect_rd("alias_wr", 32'h00, 32'hCAFE_BABE);
    expect_rd("alias_rd_hi", 32'h00 + 4 * DEPTH, 32'hCAFE_BABE);
    expect_rd("unaligned_rd", 32'h03, 32'hCAFE_BABE);
    expect_rd("neighbour_04", 32'h04, 32'h0000_EEFF);

    do_write(32'h00, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    expect_rd("wr_en_low", 32'h00, 32'hCAFE_BABE);
    do_write(32'h04, 32'hDEAD_BEEF, 4'b0000, 1'b1);
    expect_rd("be_none", 32'h04, 32'h0000_EEFF);

    do_write(32'h14, 32'h1234_5678, 4'b1111, 1'b1);
    @(negedge clk);
    adrs_rd = 32'h14;
    adrs_wr = 32'h14;
    wr_data = 32'h9ABC_DEF0;
    byt_en  = 4'b1111;
    wr_en   = 1'b1;
    sample("rw_before", 32'h1234_5678);
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    byt_en = '0;
    sample("rw_after", 32'h9ABC_DEF0);

    @(negedge clk);
    rst     = 1'b1;
    adrs_wr = 32'h20;
    wr_data = 32'h55AA_55AA;
    byt_en  = 4'b1111;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    wr_en  = 1'b0;
    byt_en = '0;
    expect_rd("rst_wr_0x20", 32'h20, 32'h0);
    expect_rd("rst_0x00b", 32'h00, 32'h0);
    expect_rd("rst_0x04", 32'h04, 32'h0);
    expect_rd("rst_0x0c", 32'h0C, 32'h0);
    expect_rd("rst_0x14", 32'h14, 32'h0);

    do_write(32'h20, 32'h0BAD_F00D, 4'b1100, 1'b1);
    expect_rd("post_rst_wr", 32'h20, 32'h0BAD_0000);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
